sim_run_monitor: RTL and testbench

Synthesizable run-control and retire-trace monitor for the pipelined CPU. It attaches to the MEM/WB stage. It starts a run on command and counts cycles and retired instructions. It stops the run on a configurable halt PC, a cycle budget, or a retire watchdog, and keeps the last `TRACE_DEPTH` retire records in a ring buffer for post-run readout. It replaces testbench-only halt and dump logic with a reusable block that can run in simulation and on the board.

---
 rtl/sim_run_monitor.sv | 144 ++++++++++++++
 tb/tb_sim_run_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_monitor.sv
// Run-control and retire-trace monitor for the MEM/WB stage: starts/stops a run,
// counts cycles and retires, and keeps the last TRACE_DEPTH retire records.
module sim_run_monitor #(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   HALT_PC     = 'h128,
    parameter int                MAX_CYCLES  = 1000,
    parameter int                STALL_LIMIT = 64,
    parameter int                TRACE_DEPTH = 32,
    parameter int                CNT_W       = 32,
    localparam int               AW          = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              clr,
    input  logic              abort,
    input  logic              wb_valid,
    input  logic [XLEN-1:0]   wb_pc,
    input  logic [31:0]       wb_inst,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wdata,
    input  logic [AW-1:0]     trc_idx,
    output logic [XLEN-1:0]   trc_pc,
    output logic [31:0]       trc_inst,
    output logic [4:0]        trc_rd,
    output logic [XLEN-1:0]   trc_wdata,
    output logic [AW:0]       trc_count,
    output logic [1:0]        state,
    output logic              done,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] STALL_C = CNT_W'(STALL_LIMIT);
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(TRACE_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } trace_rec_t;

    trace_rec_t       mem [TRACE_DEPTH];
    trace_rec_t       rd_rec;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_addr;
    logic             rd_hit;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] cycle_nxt, retire_nxt, idle_nxt;
    logic [AW:0]      count_nxt;
    logic [1:0]       exit_cause;
    logic             capture;

    assign capture = (state == S_RUN) && wb_valid;

    // Exit conditions look at the values the counters take on this edge.
    always_comb begin
        cycle_nxt  = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_ONE;
        retire_nxt = retire_cnt;
        idle_nxt   = '0;
        count_nxt  = trc_count;
        if (wb_valid) begin
            if (retire_cnt != CNT_MAX) retire_nxt = retire_cnt + CNT_ONE;
            if (trc_count != DEPTH_C)  count_nxt  = trc_count + (AW+1)'(1);
        end else begin
            idle_nxt = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + CNT_ONE;
        end

        exit_cause = 2'd0;
        if (wb_valid && wb_pc == HALT_PC)        exit_cause = 2'd1;
        else if (cycle_nxt == MAX_C)             exit_cause = 2'd2;
        else if (abort || idle_nxt == STALL_C)   exit_cause = 2'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            halt_cause <= 2'd0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            idle_cnt   <= '0;
            wr_ptr     <= '0;
            trc_count  <= '0;
        end else begin
            case (state)
                S_IDLE: if (run_en) begin
                    state      <= S_RUN;
                    halt_cause <= 2'd0;
                    cycle_cnt  <= '0;
                    retire_cnt <= '0;
                    idle_cnt   <= '0;
                    wr_ptr     <= '0;
                    trc_count  <= '0;
                end
                S_RUN: begin
                    cycle_cnt  <= cycle_nxt;
                    retire_cnt <= retire_nxt;
                    idle_cnt   <= idle_nxt;
                    trc_count  <= count_nxt;
                    if (wb_valid) wr_ptr <= wr_ptr + AW'(1);
                    if (exit_cause != 2'd0) begin
                        state      <= S_DONE;
                        halt_cause <= exit_cause;
                    end
                end
                S_DONE: if (clr) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            mem[wr_ptr] <= '{pc: wb_pc, inst: wb_inst,
                             rd: wb_regwrite ? wb_rd : 5'd0, wdata: wb_wdata};
    end

    // Index 0 is the oldest retained entry; a same-cycle write is not visible.
    assign rd_addr = wr_ptr - trc_count[AW-1:0] + trc_idx;
    assign rd_hit  = {1'b0, trc_idx} < trc_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_rec <= '0;
        else if (rd_hit) rd_rec <= mem[rd_addr];
        else             rd_rec <= '0;
    end

    assign trc_pc    = rd_rec.pc;
    assign trc_inst  = rd_rec.inst;
    assign trc_rd    = rd_rec.rd;
    assign trc_wdata = rd_rec.wdata;
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_sim_run_monitor.sv
// Scoreboard bench for sim_run_monitor: a queue/int model predicts run results and
// trace contents; a monitor process checks them as the DUT presents them.
module tb_sim_run_monitor;
    localparam int          DEPTH = 32;
    localparam int          MAXC  = 1000;
    localparam int          STALL = 64;
    localparam logic [31:0] HPC   = 32'h128;

    logic        clk = 0, rst = 1, run_en = 0, clr = 0, abort = 0;
    logic        wb_valid = 0, wb_regwrite = 0;
    logic [31:0] wb_pc = 0, wb_inst = 0, wb_wdata = 0;
    logic [4:0]  wb_rd = 0, trc_idx = 0;
    logic [31:0] trc_pc, trc_inst, trc_wdata, cycle_cnt, retire_cnt;
    logic [4:0]  trc_rd;
    logic [5:0]  trc_count;
    logic [1:0]  state, halt_cause;
    logic        done;

    sim_run_monitor dut (
        .clk(clk), .rst(rst), .run_en(run_en), .clr(clr), .abort(abort),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_wdata(wb_wdata), .trc_idx(trc_idx), .trc_pc(trc_pc),
        .trc_inst(trc_inst), .trc_rd(trc_rd), .trc_wdata(trc_wdata), .trc_count(trc_count),
        .state(state), .done(done), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc, inst, wdata; logic [4:0] rd; } rec_t;
    typedef struct { int cause, cycles, retires, count, due; } run_exp_t;
    typedef struct { rec_t r; int idx, due; } rd_exp_t;

    int       total = 0, bad = 0, cyc_g = 0;
    rec_t     trace_m[$];
    run_exp_t runq[$];
    rd_exp_t  trq[$];
    logic     done_q = 0;

    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: run results on the rising edge of done, trace reads when due.
    initial begin
        forever begin
            run_exp_t e;
            rd_exp_t  x;
            @(negedge clk);
            if (done && !done_q) begin
                if (runq.size() == 0) chk("unexpected_done", {63'b0, done}, 64'd0);
                else begin
                    e = runq.pop_front();
                    chk("done_cycle", cyc_g, e.due);
                    chk("halt_cause", halt_cause, e.cause);
                    chk("cycle_cnt", cycle_cnt, e.cycles);
                    chk("retire_cnt", retire_cnt, e.retires);
                    chk("trc_count", trc_count, e.count);
                    chk("state_done", state, 2);
                end
            end
            done_q = done;
            if (trq.size() > 0 && cyc_g >= trq[0].due) begin
                x = trq.pop_front();
                chk($sformatf("trc_pc[%0d]", x.idx), trc_pc, x.r.pc);
                chk($sformatf("trc_inst[%0d]", x.idx), trc_inst, x.r.inst);
                chk($sformatf("trc_rd[%0d]", x.idx), trc_rd, x.r.rd);
                chk($sformatf("trc_wdata[%0d]", x.idx), trc_wdata, x.r.wdata);
            end
        end
    end

    task automatic do_read(int idx);
        rd_exp_t x;
        trc_idx = 5'(idx);
        if (idx < trace_m.size()) x.r = trace_m[idx];
        else begin x.r.pc = 0; x.r.inst = 0; x.r.rd = 0; x.r.wdata = 0; end
        x.idx = idx;
        x.due = cyc_g + 2;
        trq.push_back(x);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(string nm);
        int n = 0;
        while ((runq.size() > 0 || trq.size() > 0) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_pending"}, runq.size() + trq.size(), 0);
        runq.delete();
        trq.delete();
    endtask

    // mode: 0 halt-PC walk, 1 budget, 2 watchdog, 3 priority, 4 random, 5 rd mask
    task automatic do_run(int mode);
        int cyc = 0, ret = 0, idle = 0, cause = 0, n;
        logic v, rw, ab;
        logic [31:0] pc, inst, wd;
        logic [4:0] rd;
        rec_t r;
        run_exp_t e;
        trace_m.delete();
        @(negedge clk); run_en = 1; clr = 1'($urandom);
        @(negedge clk); run_en = 0; clr = 0;
        chk("start_state", state, 1);
        chk("start_cycle", cycle_cnt, 0);
        chk("start_count", trc_count, 0);
        chk("start_cause", halt_cause, 0);
        while (cause == 0 && cyc < 3000) begin
            ab = 0; rw = 1'($urandom); rd = 5'($urandom); inst = $urandom; wd = $urandom;
            case (mode)
                0: begin v = 1; pc = cyc * 4; end
                1: begin v = (cyc % 2 == 0); pc = 32'h1000 + ret * 4; end
                2: begin v = (cyc == 0); pc = 32'h200; end
                3: begin v = 1; pc = (cyc == 999) ? HPC : 32'h2000 + cyc * 4; ab = (cyc == 999); end
                4: begin
                    v  = ($urandom_range(0, 9) < 7);
                    pc = ($urandom_range(0, 99) == 0) ? HPC : $urandom_range(0, 1023) * 4;
                    ab = ($urandom_range(0, 499) == 0);
                end
                default: begin v = (cyc == 0); rw = (cyc != 0); rd = 5; pc = 32'h300; ab = (cyc == 1); end
            endcase
            wb_valid = v; wb_pc = pc; wb_inst = inst; wb_regwrite = rw; wb_rd = rd;
            wb_wdata = wd; abort = ab;
            cyc++;
            if (v) begin
                ret++;
                r.pc = pc; r.inst = inst; r.rd = rw ? rd : 5'd0; r.wdata = wd;
                trace_m.push_back(r);
                if (trace_m.size() > DEPTH) void'(trace_m.pop_front());
                idle = 0;
            end else idle++;
            if (v && pc == HPC)             cause = 1;
            else if (cyc == MAXC)           cause = 2;
            else if (ab || idle == STALL)   cause = 3;
            if (cause != 0) begin
                e.cause = cause; e.cycles = cyc; e.retires = ret;
                e.count = trace_m.size(); e.due = cyc_g + 1;
                runq.push_back(e);
            end
            @(negedge clk);
        end
        wb_valid = 0; abort = 0;
        drain("run");
        // DONE must ignore retires, abort and run_en.
        wb_valid = 1; wb_pc = HPC; abort = 1; run_en = 1;
        repeat (3) @(negedge clk);
        wb_valid = 0; abort = 0; run_en = 0;
        chk("frozen_state", state, 2);
        chk("frozen_cycle", cycle_cnt, cyc);
        chk("frozen_retire", retire_cnt, ret);
        chk("frozen_count", trc_count, trace_m.size());
        do_read(0);
        do_read(trace_m.size() > 0 ? trace_m.size() - 1 : 0);
        do_read($urandom_range(0, DEPTH - 1));
        if (trace_m.size() < DEPTH) do_read(trace_m.size());
        if (mode == 5) do_read(3);
        drain("read");
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        chk("clr_state", state, 0);
        chk("clr_done", done, 0);
        chk("clr_cycle_kept", cycle_cnt, cyc);
        chk("clr_cause_kept", halt_cause, cause);
        n = 0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_count", trc_count, 0);
        chk("rst_trc_pc", trc_pc, 0);
        rst = 0;
        do_run(5);
        do_run(0);
        do_run(1);
        do_run(2);
        do_run(3);
        // Reset in the middle of a run, away from the clock edge.
        @(negedge clk); run_en = 1;
        @(negedge clk); run_en = 0; trc_idx = 0;
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1; wb_pc = 32'h4000 + i * 4; wb_regwrite = 1; wb_rd = 5'(i + 1);
            @(negedge clk);
        end
        wb_valid = 0;
        chk("midrun_cycle", cycle_cnt, 10);
        chk("midrun_trc_pc", trc_pc, 32'h4000);
        #2 rst = 1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_cycle", cycle_cnt, 0);
        chk("arst_retire", retire_cnt, 0);
        chk("arst_count", trc_count, 0);
        chk("arst_trc_pc", trc_pc, 0);
        @(negedge clk); rst = 0;
        do_run(0);
        for (int k = 0; k < 6; k++) do_run(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1, "timeout");
    end
endmodule
